// File: rtl/prime_search_ctrl.sv
// prime_search_ctrl: sequencer for the prime-search datapath.
// Sweeps a candidate from FIRST up to a latched limit. Each candidate goes to
// an external checker, and every prime is written to the result RAM. The sweep
// stops at the limit or when the RAM is full. The unit then cycles the RAM read
// address for the display stage.
//
// Checker handshake: chk_start is a one-cycle request and chk_value is held
// stable until the reply. The reply is valid in any cycle after the request
// where chk_done=1, and chk_prime is meaningful only in that cycle. A chk_done
// seen in the request cycle itself is not a reply and is dropped.
module prime_search_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int FIRST  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go_btn,
  input  logic              abort,
  input  logic [DATA_W-1:0] limit,
  output logic              chk_start,
  output logic [DATA_W-1:0] chk_value,
  input  logic              chk_done,
  input  logic              chk_prime,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] raddr,
  output logic              sel,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  input  logic              disp_tick,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_STORE   = 3'd3,
    S_NEXT    = 3'd4,
    S_DISPLAY = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] FIRST_V  = DATA_W'(FIRST);
  localparam logic [ADDR_W:0]   DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                go_s_q, go_d_q;
  logic [DATA_W-1:0]   limit_q, limit_d;
  logic [DATA_W-1:0]   chk_value_q, chk_value_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;

  logic                go_edge;
  logic                start_run;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W:0]     count_m1;

  // Rising edge of the registered button. Both stages reset high, so a button
  // already held at reset release never counts as an edge.
  assign go_edge   = go_s_q & ~go_d_q;
  assign count_inc = count_q + CNT_ONE;
  assign count_m1  = count_q - CNT_ONE;

  // A go edge is honoured only when idle or displaying, and abort beats it.
  assign start_run = go_edge && !abort &&
                     ((state_q == S_IDLE) || (state_q == S_DISPLAY));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: button synchroniser, limit, candidate, addresses, count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_s_q      <= 1'b1;
      go_d_q      <= 1'b1;
      limit_q     <= '0;
      chk_value_q <= FIRST_V;
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
    end else begin
      go_s_q      <= go_btn;
      go_d_q      <= go_s_q;
      limit_q     <= limit_d;
      chk_value_q <= chk_value_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      full_q      <= full_d;
    end
  end

  // Next-state and datapath update; a new run overrides the display step.
  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    chk_value_d = chk_value_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    full_d      = full_q;

    if (abort) begin
      // Back to idle; results so far (count, full, RAM) are kept.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (chk_done) begin
            state_d = chk_prime ? S_STORE : S_NEXT;
          end
        end
        S_STORE: begin
          count_d = count_inc;
          waddr_d = waddr_q + ADDR_ONE;
          if (count_inc == DEPTH_V) begin
            full_d  = 1'b1;
            state_d = S_DISPLAY;
          end else begin
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (chk_value_q == limit_q) begin
            state_d = S_DISPLAY;
          end else begin
            chk_value_d = chk_value_q + DATA_ONE;
            state_d     = S_LAUNCH;
          end
        end
        S_DISPLAY: begin
          if (disp_tick) begin
            if (count_q == '0) begin
              raddr_d = '0;
            end else if ({1'b0, raddr_q} == count_m1) begin
              raddr_d = '0;
            end else begin
              raddr_d = raddr_q + ADDR_ONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (start_run) begin
      limit_d     = limit;
      count_d     = '0;
      waddr_d     = '0;
      raddr_d     = '0;
      full_d      = 1'b0;
      chk_value_d = FIRST_V;
      state_d     = (limit < FIRST_V) ? S_DISPLAY : S_LAUNCH;
    end
  end

  // Outputs are registers or pure state decodes.
  assign chk_start   = (state_q == S_LAUNCH);
  assign we          = (state_q == S_STORE);
  assign sel         = (state_q == S_DISPLAY);
  assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                       (state_q == S_STORE)  || (state_q == S_NEXT);
  assign chk_value   = chk_value_q;
  assign wdata       = chk_value_q;
  assign waddr       = waddr_q;
  assign raddr       = raddr_q;
  assign count       = count_q;
  assign full        = full_q;
  assign dbg_state_o = state_q;

endmodule
